// File: rtl/tile_feeder_pkg.sv
// Shared types and constants for the tile_feeder block.
// Optional feature macro: TILE_FEEDER_FLUSH_EN adds a trailing flush beat per command.
package tile_feeder_pkg;

  localparam int unsigned A_W     = 8;
  localparam int unsigned B_W     = 19;
  localparam int unsigned SHIFT_W = 4;

`ifdef TILE_FEEDER_FLUSH_EN
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRELOAD = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_FLUSH   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRELOAD = 2'd1,
    ST_COMPUTE = 2'd2
  } state_t;
`endif

  // Per-beat control word presented to the Tile alongside the data
  typedef struct packed {
    logic               propagate;
    logic [SHIFT_W-1:0] shift;
  } ctrl_t;

endpackage

// File: rtl/tile_feeder_out_reg.sv
// Registered Tile-facing output bank: payload loads on 'load', valid strobes for one cycle.
module tile_feeder_out_reg
  import tile_feeder_pkg::*;
#(
  parameter int unsigned DBITS = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [A_W-1:0]   load_a,
  input  logic [B_W-1:0]   load_b,
  input  logic [DBITS-1:0] load_d,
  input  ctrl_t            load_ctrl,
  output logic [A_W-1:0]   a,
  output logic [B_W-1:0]   b,
  output logic [DBITS-1:0] d,
  output ctrl_t            ctrl,
  output logic             valid
);

  // Valid follows the load strobe one cycle later; the Tile has no backpressure
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
    end else begin
      valid <= load;
    end
  end

  // Payload and control hold their last beat between loads
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a    <= '0;
      b    <= '0;
      d    <= '0;
      ctrl <= '0;
    end else if (load) begin
      a    <= load_a;
      b    <= load_b;
      d    <= load_d;
      ctrl <= load_ctrl;
    end
  end

endmodule

// File: rtl/tile_feeder.sv
// Transmit-side driver for a single-PE mesh Tile: one preload beat then len compute beats
// per command, with the propagate bit toggling per command.
// Optional feature macro: TILE_FEEDER_FLUSH_EN appends a zero-data flush beat with
// inverted propagate so the final accumulator leaves the PE before done.
module tile_feeder
  import tile_feeder_pkg::*;
#(
  parameter int unsigned DBITS = 32,
  parameter int unsigned LEN_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [SHIFT_W-1:0] cmd_shift,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_W-1:0]     in_a,
  input  logic [B_W-1:0]     in_b,
  input  logic [DBITS-1:0]   in_d,
  output logic [A_W-1:0]     io_out_a_0,
  output logic [B_W-1:0]     io_out_b_0,
  output logic [DBITS-1:0]   io_out_d_0,
  output logic               io_out_control_0_propagate,
  output logic [SHIFT_W-1:0] io_out_control_0_shift,
  output logic               io_out_valid_0,
  output logic               busy,
  output logic               done
);

  state_t             state, state_nxt;
  logic [LEN_W-1:0]   cnt, cnt_nxt;
  logic [LEN_W-1:0]   len_q, len_nxt;
  logic [SHIFT_W-1:0] shift_q, shift_nxt;
  logic               prop_q, prop_nxt;
  logic               done_q, done_nxt;

  logic               ld;
  logic [A_W-1:0]     ld_a;
  logic [B_W-1:0]     ld_b;
  logic [DBITS-1:0]   ld_d;
  ctrl_t              ld_ctrl;
  ctrl_t              out_ctrl;
  logic               last_beat;

  // Handshake readiness depends on state only
  assign cmd_ready = (state == ST_IDLE);
  assign in_ready  = (state == ST_PRELOAD) || (state == ST_COMPUTE);
  assign busy      = (state != ST_IDLE);
  assign done      = done_q;

  // State, command latches, propagate phase and beat counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      len_q   <= '0;
      shift_q <= '0;
      prop_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      len_q   <= len_nxt;
      shift_q <= shift_nxt;
      prop_q  <= prop_nxt;
      done_q  <= done_nxt;
    end
  end

  // Next-state logic and the beat to be loaded into the output bank
  always_comb begin
    state_nxt         = state;
    cnt_nxt           = cnt;
    len_nxt           = len_q;
    shift_nxt         = shift_q;
    prop_nxt          = prop_q;
    done_nxt          = 1'b0;
    last_beat         = 1'b0;
    ld                = 1'b0;
    ld_a              = '0;
    ld_b              = '0;
    ld_d              = '0;
    ld_ctrl.propagate = prop_q;
    ld_ctrl.shift     = shift_q;

    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          shift_nxt = cmd_shift;
          len_nxt   = cmd_len;
          prop_nxt  = ~prop_q;
          cnt_nxt   = '0;
          state_nxt = ST_PRELOAD;
        end
      end

      ST_PRELOAD: begin
        if (in_valid) begin
          ld   = 1'b1;
          ld_d = in_d;
          if (len_q != '0) begin
            state_nxt = ST_COMPUTE;
          end else begin
            last_beat = 1'b1;
          end
        end
      end

      ST_COMPUTE: begin
        if (in_valid) begin
          ld      = 1'b1;
          ld_a    = in_a;
          ld_b    = in_b;
          // cnt tops out at len, which always fits in LEN_W bits
          cnt_nxt = cnt + LEN_W'(1);
          if (cnt == len_q - LEN_W'(1)) begin
            last_beat = 1'b1;
          end
        end
      end

`ifdef TILE_FEEDER_FLUSH_EN
      ST_FLUSH: begin
        // Zero beat with the opposite accumulator selected pushes the result out
        ld                = 1'b1;
        ld_ctrl.propagate = ~prop_q;
        done_nxt          = 1'b1;
        state_nxt         = ST_IDLE;
      end
`endif

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (last_beat) begin
`ifdef TILE_FEEDER_FLUSH_EN
      state_nxt = ST_FLUSH;
`else
      done_nxt  = 1'b1;
      state_nxt = ST_IDLE;
`endif
    end
  end

  // Registered Tile-facing outputs
  tile_feeder_out_reg #(
    .DBITS (DBITS)
  ) u_out_reg (
    .clock     (clock),
    .reset     (reset),
    .load      (ld),
    .load_a    (ld_a),
    .load_b    (ld_b),
    .load_d    (ld_d),
    .load_ctrl (ld_ctrl),
    .a         (io_out_a_0),
    .b         (io_out_b_0),
    .d         (io_out_d_0),
    .ctrl      (out_ctrl),
    .valid     (io_out_valid_0)
  );

  assign io_out_control_0_propagate = out_ctrl.propagate;
  assign io_out_control_0_shift     = out_ctrl.shift;

endmodule
